// File: rtl/st_timing_adapter_buf_if.sv
// Avalon-ST handshake bundle for st_timing_adapter_buf: upstream beat/grant,
// downstream beat/ready, and occupancy/error status.
interface st_timing_adapter_buf_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;
  logic [CW-1:0]         fill_level;
  logic                  overflow;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, fill_level, overflow
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, fill_level, overflow
  );
endinterface

// File: rtl/st_timing_adapter_buf.sv
// Avalon-ST timing adapter: converts upstream/downstream ready latencies and
// absorbs backpressure in a DEPTH-entry FIFO with a sticky overflow flag.
module st_timing_adapter_buf #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned IN_READY_LATENCY  = 0,
  parameter int unsigned OUT_READY_LATENCY = 0,
  parameter int unsigned DEPTH             = 4
) (
  input logic                    clk,
  input logic                    reset,
  st_timing_adapter_buf_if.slave st
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow_q;
  logic                  in_ready_c;
  logic                  out_valid_c;
  logic                  grant;
  logic                  push;
  logic                  pop;
  logic                  illegal;

  // Upstream grant generation; with latency, outstanding grants reserve space.
  if (IN_READY_LATENCY == 0) begin : g_lat0
    assign in_ready_c = !reset && (count < CW'(DEPTH));
    assign grant      = in_ready_c;
  end else begin : g_latn
    localparam int unsigned L  = IN_READY_LATENCY;
    localparam int unsigned SW = $clog2(DEPTH + IN_READY_LATENCY + 1) + 1;

    logic [L-1:0]  grant_sr;
    logic [SW-1:0] pending;

    assign pending    = SW'($countones(grant_sr));
    assign in_ready_c = !reset && ((SW'(count) + pending) < SW'(DEPTH));
    assign grant      = grant_sr[L-1];

    always_ff @(posedge clk) begin
      if (reset) grant_sr <= '0;
      else       grant_sr <= L'({grant_sr, in_ready_c});
    end
  end

  // Downstream valid; with latency 1 every valid cycle is consumed.
  if (OUT_READY_LATENCY == 0) begin : g_rdy0
    assign out_valid_c = (count != '0);
    assign pop         = out_valid_c && st.out_ready;
  end else begin : g_rdy1
    logic rdy_d;

    always_ff @(posedge clk) begin
      if (reset) rdy_d <= 1'b0;
      else       rdy_d <= st.out_ready;
    end

    assign out_valid_c = (count != '0) && rdy_d;
    assign pop         = out_valid_c;
  end

  // A beat without its grant, or into a full buffer, is dropped and flagged.
  always_comb begin
    push    = 1'b0;
    illegal = 1'b0;
    if (st.in_valid) begin
      if (grant && (count != CW'(DEPTH))) push    = 1'b1;
      else                                illegal = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem        <= '{default: '0};
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= st.in_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (illegal) overflow_q <= 1'b1;
    end
  end

  assign st.in_ready   = in_ready_c;
  assign st.out_valid  = out_valid_c;
  assign st.out_data   = mem[rd_ptr];
  assign st.fill_level = count;
  assign st.overflow   = overflow_q;
endmodule

// File: tb/tb_st_timing_adapter_buf.sv
// Bench for st_timing_adapter_buf: three configurations (L0/RL0, L2/RL0, L0/RL1)
// driven by vector tables and hand sequences, output data checked against a scoreboard.
module tb_st_timing_adapter_buf;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  st_timing_adapter_buf_if #(.DATA_WIDTH(8), .DEPTH(4)) ia ();
  st_timing_adapter_buf_if #(.DATA_WIDTH(8), .DEPTH(4)) ib ();
  st_timing_adapter_buf_if #(.DATA_WIDTH(8), .DEPTH(4)) ic ();

  st_timing_adapter_buf #(.DATA_WIDTH(8), .IN_READY_LATENCY(0), .OUT_READY_LATENCY(0), .DEPTH(4))
    dut_a (.clk(clk), .reset(rst), .st(ia.slave));
  st_timing_adapter_buf #(.DATA_WIDTH(8), .IN_READY_LATENCY(2), .OUT_READY_LATENCY(0), .DEPTH(4))
    dut_b (.clk(clk), .reset(rst), .st(ib.slave));
  st_timing_adapter_buf #(.DATA_WIDTH(8), .IN_READY_LATENCY(0), .OUT_READY_LATENCY(1), .DEPTH(4))
    dut_c (.clk(clk), .reset(rst), .st(ic.slave));

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } sb_t;

  typedef struct {
    int         w;
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       e_ir;
    logic       e_ov;
    logic [2:0] e_fill;
  } vec_t;

  typedef struct {
    logic       ir;
    logic       ov;
    logic [7:0] od;
    logic [2:0] fl;
    logic       of;
  } obs_t;

  sb_t  qa[$];
  sb_t  qb[$];
  sb_t  qc[$];
  vec_t tbl[$];

  int nvec;
  int nerr;
  int cyc;
  bit lat_chk;

  int t3_ir[10]   = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
  int t3_fill[10] = '{0, 0, 0, 1, 2, 3, 4, 4, 4, 4};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input int w, input logic v, input logic [7:0] d, input logic r);
    case (w)
      0: begin ia.in_valid = v; ia.in_data = d; ia.out_ready = r; end
      1: begin ib.in_valid = v; ib.in_data = d; ib.out_ready = r; end
      default: begin ic.in_valid = v; ic.in_data = d; ic.out_ready = r; end
    endcase
  endtask

  task automatic sb_push(input int w, input logic [7:0] d);
    sb_t e;
    e.data = d;
    e.cyc  = cyc;
    case (w)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  function automatic obs_t sample(input int w);
    obs_t o;
    case (w)
      0:       o = '{ia.in_ready, ia.out_valid, ia.out_data, ia.fill_level, ia.overflow};
      1:       o = '{ib.in_ready, ib.out_valid, ib.out_data, ib.fill_level, ib.overflow};
      default: o = '{ic.in_ready, ic.out_valid, ic.out_data, ic.fill_level, ic.overflow};
    endcase
    return o;
  endfunction

  // Waits for the falling edge and retires any beat each DUT delivers this cycle.
  task automatic settle();
    sb_t e;
    @(negedge clk);
    if (!rst) begin
      if (ia.out_valid && ia.out_ready) begin
        check("a_sb_has_entry", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) begin
          e = qa.pop_front();
          check("a_out_data", 32'(ia.out_data), 32'(e.data));
          if (lat_chk) check("a_latency", 32'(cyc), 32'(e.cyc + 1));
        end
      end
      if (ib.out_valid && ib.out_ready) begin
        check("b_sb_has_entry", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) begin
          e = qb.pop_front();
          check("b_out_data", 32'(ib.out_data), 32'(e.data));
        end
      end
      if (ic.out_valid) begin
        check("c_sb_has_entry", 32'(qc.size() != 0), 32'd1);
        if (qc.size() != 0) begin
          e = qc.pop_front();
          check("c_out_data", 32'(ic.out_data), 32'(e.data));
        end
      end
    end
  endtask

  function automatic vec_t mk(input int w, input logic v, input logic [7:0] d, input logic r,
                              input logic e_ir, input logic e_ov, input logic [2:0] e_fill);
    vec_t t;
    t = '{w, v, d, r, e_ir, e_ov, e_fill};
    return t;
  endfunction

  task automatic run_table(input string tag);
    obs_t o;
    foreach (tbl[i]) begin
      tick();
      drive(tbl[i].w, tbl[i].v, tbl[i].d, tbl[i].r);
      if (tbl[i].v) sb_push(tbl[i].w, tbl[i].d);
      settle();
      o = sample(tbl[i].w);
      check($sformatf("%s_row%0d_in_ready", tag, i), 32'(o.ir), 32'(tbl[i].e_ir));
      check($sformatf("%s_row%0d_out_valid", tag, i), 32'(o.ov), 32'(tbl[i].e_ov));
      check($sformatf("%s_row%0d_fill", tag, i), 32'(o.fl), 32'(tbl[i].e_fill));
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    for (int w = 0; w < 3; w++) drive(w, 1'b0, 8'h00, 1'b0);
    settle();
    tick();
    rst = 1'b0;
    settle();
    qa.delete();
    qb.delete();
    qc.delete();
  endtask

  initial begin
    obs_t       o;
    logic [1:0] gh;

    nvec    = 0;
    nerr    = 0;
    cyc     = 0;
    lat_chk = 1'b0;
    rst     = 1'b1;
    for (int w = 0; w < 3; w++) drive(w, 1'b0, 8'h00, 1'b0);

    // Reset values, during and just after reset.
    tick();
    settle();
    for (int w = 0; w < 3; w++) begin
      o = sample(w);
      check($sformatf("rst%0d_in_ready_during", w), 32'(o.ir), 32'd0);
    end
    tick();
    rst = 1'b0;
    settle();
    for (int w = 0; w < 3; w++) begin
      o = sample(w);
      check($sformatf("rst%0d_in_ready", w), 32'(o.ir), 32'd1);
      check($sformatf("rst%0d_out_valid", w), 32'(o.ov), 32'd0);
      check($sformatf("rst%0d_out_data", w), 32'(o.od), 32'd0);
      check($sformatf("rst%0d_fill", w), 32'(o.fl), 32'd0);
      check($sformatf("rst%0d_overflow", w), 32'(o.of), 32'd0);
    end

    // Back-to-back stream with downstream always ready.
    lat_chk = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      drive(0, 1'b1, 8'(i), 1'b1);
      sb_push(0, 8'(i));
      settle();
      o = sample(0);
      check("t1_in_ready", 32'(o.ir), 32'd1);
      check("t1_fill_le1", 32'(o.fl <= 3'd1), 32'd1);
      check("t1_overflow", 32'(o.of), 32'd0);
    end
    tick();
    drive(0, 1'b0, 8'h00, 1'b1);
    settle();
    tick();
    settle();
    lat_chk = 1'b0;
    check("t1_all_delivered", 32'(qa.size()), 32'd0);

    // Fill to full under backpressure, pop while full, drain, then push+pop.
    tbl.push_back(mk(0, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 3'd0));
    tbl.push_back(mk(0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 3'd1));
    tbl.push_back(mk(0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 3'd2));
    tbl.push_back(mk(0, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 3'd3));
    tbl.push_back(mk(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4));
    tbl.push_back(mk(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd4));
    tbl.push_back(mk(0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd3));
    tbl.push_back(mk(0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd2));
    tbl.push_back(mk(0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd1));
    tbl.push_back(mk(0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0));
    tbl.push_back(mk(0, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b0, 3'd0));
    tbl.push_back(mk(0, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b1, 3'd1));
    tbl.push_back(mk(0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd1));
    tbl.push_back(mk(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0));
    run_table("t2");
    check("t2_overflow", 32'(ia.overflow), 32'd0);
    check("t2_all_delivered", 32'(qa.size()), 32'd0);

    // Latency-2 upstream sending only on granted slots, downstream stalled.
    gh = 2'b00;
    for (int t = 0; t < 10; t++) begin
      tick();
      drive(1, gh[1], 8'h30 + 8'(t), 1'b0);
      if (gh[1]) sb_push(1, 8'h30 + 8'(t));
      settle();
      o = sample(1);
      check($sformatf("t3_c%0d_in_ready", t), 32'(o.ir), 32'(t3_ir[t]));
      check($sformatf("t3_c%0d_fill", t), 32'(o.fl), 32'(t3_fill[t]));
      check($sformatf("t3_c%0d_overflow", t), 32'(o.of), 32'd0);
      gh = {gh[0], o.ir};
    end
    tick();
    drive(1, 1'b1, 8'hEE, 1'b0);
    settle();
    check("t3_overflow_before_edge", 32'(ib.overflow), 32'd0);
    tick();
    drive(1, 1'b0, 8'h00, 1'b0);
    settle();
    check("t3_overflow_set", 32'(ib.overflow), 32'd1);
    check("t3_fill_unchanged", 32'(ib.fill_level), 32'd4);
    for (int t = 0; t < 5; t++) begin
      tick();
      drive(1, 1'b0, 8'h00, 1'b1);
      settle();
    end
    check("t3_drained", 32'(ib.fill_level), 32'd0);
    check("t3_all_delivered", 32'(qb.size()), 32'd0);
    check("t3_overflow_sticky", 32'(ib.overflow), 32'd1);

    // Downstream ready latency 1 with out_ready toggling.
    tbl.push_back(mk(2, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 3'd0));
    tbl.push_back(mk(2, 1'b1, 8'hBB, 1'b0, 1'b1, 1'b0, 3'd1));
    tbl.push_back(mk(2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd2));
    tbl.push_back(mk(2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd2));
    tbl.push_back(mk(2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd1));
    tbl.push_back(mk(2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd1));
    tbl.push_back(mk(2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0));
    run_table("t4");
    check("t4_all_delivered", 32'(qc.size()), 32'd0);

    // Reset with three beats buffered and one grant in flight.
    do_reset();
    check("t5_overflow_cleared", 32'(ib.overflow), 32'd0);
    gh = 2'b00;
    for (int t = 0; t < 5; t++) begin
      tick();
      drive(1, gh[1], 8'h50 + 8'(t), 1'b0);
      if (gh[1]) sb_push(1, 8'h50 + 8'(t));
      settle();
      o = sample(1);
      gh = {gh[0], o.ir};
    end
    tick();
    rst = 1'b1;
    drive(1, gh[1], 8'h55, 1'b0);
    settle();
    check("t5_in_valid_during_reset", 32'(ib.in_valid), 32'(gh[1]));
    check("t5_in_ready_in_reset", 32'(ib.in_ready), 32'd0);
    check("t5_fill_before_reset", 32'(ib.fill_level), 32'd3);
    qb.delete();
    tick();
    rst = 1'b0;
    drive(1, 1'b0, 8'h00, 1'b1);
    settle();
    o = sample(1);
    check("t5_fill", 32'(o.fl), 32'd0);
    check("t5_out_valid", 32'(o.ov), 32'd0);
    check("t5_out_data", 32'(o.od), 32'd0);
    check("t5_overflow", 32'(o.of), 32'd0);
    check("t5_in_ready", 32'(o.ir), 32'd1);
    for (int t = 0; t < 3; t++) begin
      tick();
      settle();
      check($sformatf("t5_quiet%0d_out_valid", t), 32'(ib.out_valid), 32'd0);
      check($sformatf("t5_quiet%0d_fill", t), 32'(ib.fill_level), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/st_timing_adapter_buf.md
# st_timing_adapter_buf

Parametrised Avalon-ST timing adapter with an internal buffer. It sits between the HPS master byte stream and downstream Avalon-ST sinks. It converts between upstream and downstream ready latencies and absorbs downstream backpressure in a DEPTH-entry FIFO, rather than only warning about it. Protocol violations and overruns are flagged with a sticky status bit instead of silently corrupting the stream.

## Interface
- DATA_WIDTH, 8: payload width in bits.
- IN_READY_LATENCY, 0: upstream ready latency, legal 0..3.
- OUT_READY_LATENCY, 0: downstream ready latency, legal 0 or 1.
- DEPTH, 4: FIFO entries; power of 2, >= 2, and >= IN_READY_LATENCY+1.

- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_data  in  DATA_WIDTH  upstream payload.
- in_ready  out  1  upstream grant, honouring IN_READY_LATENCY semantics.
- out_valid  out  1  downstream beat valid.
- out_data  out  DATA_WIDTH  downstream payload (FIFO head).
- out_ready  in  1  downstream ready, honouring OUT_READY_LATENCY semantics.
- fill_level  out  $clog2(DEPTH+1)  current FIFO occupancy.
- overflow  out  1  sticky error flag; cleared only by reset.

## Operation
- Storage: DEPTH x DATA_WIDTH register array. Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count runs 0..DEPTH. fill_level = count.
- Grant tracking, IN_READY_LATENCY = L:
  - grant_sr is an L-bit shift register of past in_ready values.
  - pending = popcount(grant_sr), i.e. grants whose beat slot has not yet arrived.
  - L=0: in_ready = (count < DEPTH).
  - L>0: in_ready = (count + pending) < DEPTH.
  - in_ready never depends combinationally on out_ready.
- Write (push):
  - L=0: push when in_valid && in_ready.
  - L>0: push when in_valid && grant_sr[L-1], i.e. the grant issued L cycles earlier.
- Illegal beat: in_valid high without the corresponding grant, or arriving while count == DEPTH.
  - The beat is dropped; FIFO contents are unchanged.
  - overflow <= 1 on the next edge.
- Read (pop):
  - OUT_READY_LATENCY=0: out_valid = (count != 0); pop when out_valid && out_ready.
  - OUT_READY_LATENCY=1: register rdy_d <= out_ready. out_valid = (count != 0) && rdy_d; every out_valid cycle is a pop.
- out_data = storage[rd_ptr] (combinational read of the head).
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full with a pop in the same cycle: in_ready stays low that cycle (no bypass path). The freed slot is granted from the next cycle.
- Empty with a push: no flow-through. The beat appears on out_valid one cycle after the push edge.
- Reset mid-stream:
  - All buffered beats are discarded.
  - Grants in flight are cancelled (grant_sr cleared).
  - Beats arriving on in_valid during reset are ignored and do not set overflow.

## Timing
- Reset values: in_ready 0 while reset is high; from the first cycle after reset, in_ready = 1.
- Reset values: out_valid 0, out_data 0 (storage cleared), fill_level 0, overflow 0, pointers 0, grant_sr 0, rdy_d 0.
- Latency from accepted input to out_valid: 1 cycle, plus 1 more cycle when OUT_READY_LATENCY=1 and rdy_d is low.
- Throughput: 1 beat/cycle sustained when out_ready is held high and DEPTH >= L+1.
- fill_level and overflow are registered. in_ready and out_valid are combinational from registers only.

## Test plan
- L=0, RL_out=0, DEPTH=4, out_ready=1, push 0x01..0x10 back-to-back -> out_data 0x01..0x10 in order, each one cycle after its push, fill_level <= 1, overflow 0.
- out_ready=0, push until in_ready drops -> exactly 4 beats accepted, fill_level=4, in_ready=0; raise out_ready -> 4 beats drain in order, then in_ready returns to 1.
- L=2, DEPTH=4, out_ready=0, upstream sends only on granted slots -> at most 4 beats accepted, no overflow. Then force in_valid on an ungranted cycle -> beat dropped, overflow=1 and stays 1 until reset.
- RL_out=1, toggle out_ready 1,0,1,0 with FIFO holding 0xAA,0xBB -> out_valid only in cycles following out_ready=1; 0xAA then 0xBB delivered.
- Full FIFO with simultaneous pop request -> in_ready stays 0 in that cycle; fill_level goes 4->3; in_ready=1 the next cycle.
- Assert reset with 3 beats buffered and 1 grant pending -> next cycle fill_level=0, out_valid=0, out_data=0, overflow=0; a late in_valid during reset produces no output.
